// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: cache miss interface to AXI4 master bridge (optional macro BRIDGE_RD_BYPASS_EN)
module cache_axi_bridge #(
    parameter logic [3:0] RD_ID = 4'd0,
    parameter logic [3:0] WR_ID = 4'd1,
    parameter int         WIDTH = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rd_req,
    input  logic [2:0]         rd_type,
    input  logic [31:0]        rd_addr,
    output logic               rd_rdy,
    output logic               ret_valid,
    output logic               ret_last,
    output logic [31:0]        ret_data,
    input  logic               wr_req,
    input  logic [2:0]         wr_type,
    input  logic [31:0]        wr_addr,
    input  logic [3:0]         wr_wstrb,
    input  logic [WIDTH*8-1:0] wr_data,
    output logic               wr_rdy,
    output logic [3:0]         arid,
    output logic [31:0]        araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    output logic               arvalid,
    input  logic               arready,
    input  logic [3:0]         rid,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    input  logic               rvalid,
    output logic               rready,
    output logic [3:0]         awid,
    output logic [31:0]        awaddr,
    output logic [7:0]         awlen,
    output logic [2:0]         awsize,
    output logic [1:0]         awburst,
    output logic               awvalid,
    input  logic               awready,
    output logic [31:0]        wdata,
    output logic [3:0]         wstrb,
    output logic               wlast,
    output logic               wvalid,
    input  logic               wready,
    input  logic [3:0]         bid,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready
);
    localparam int         BEATS    = WIDTH / 4;
    localparam int         CW       = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [7:0] LINE_LEN = 8'(BEATS - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    function automatic logic [7:0] len_of(input logic [2:0] t);
        return t[2] ? LINE_LEN : 8'd0;
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] t);
        return (t[2] || t[1]) ? 3'd2 : (t[0] ? 3'd1 : 3'd0);
    endfunction

    r_state_t                  r_state_q;
    logic [31:0]               raddr_q;
    logic [2:0]                rtype_q;
    logic                      arvalid_q;

    w_state_t                  w_state_q;
    logic [31:0]               waddr_q;
    logic [2:0]                wtype_q;
    logic [3:0]                wstrb_q;
    logic [BEATS-1:0][31:0]    wbuf_q;
    logic [CW-1:0]             cnt_q;
    logic                      awvalid_q;
    logic                      wvalid_q;

    logic                      w_busy;
    logic                      rd_hz;
    logic                      ar_hz;
    logic                      acc_hz;
    logic                      aw_fin;
    logic                      w_fin;
    logic                      unused_ok;

    assign w_busy = w_state_q != W_IDLE;

`ifdef BRIDGE_RD_BYPASS_EN
    // Only a read that hits the line being written must wait for the write response.
    assign rd_hz  = w_busy && rd_addr[31:4] == waddr_q[31:4];
    assign ar_hz  = w_busy && raddr_q[31:4] == waddr_q[31:4];
    assign acc_hz = rd_addr[31:4] == wr_addr[31:4];
`else
    // Any pending write blocks reads, giving strict write-before-read ordering.
    assign rd_hz  = w_busy;
    assign ar_hz  = w_busy;
    assign acc_hz = 1'b1;
`endif

    assign rd_rdy    = resetn && r_state_q == R_IDLE && !rd_hz;
    assign ret_valid = resetn && r_state_q == R_DATA && rvalid;
    assign ret_last  = ret_valid && rlast;
    assign ret_data  = rdata;
    assign rready    = r_state_q == R_DATA;

    assign arid    = RD_ID;
    assign araddr  = raddr_q;
    assign arlen   = len_of(rtype_q);
    assign arsize  = size_of(rtype_q);
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;

    assign wr_rdy  = resetn && w_state_q == W_IDLE;
    assign awid    = WR_ID;
    assign awaddr  = waddr_q;
    assign awlen   = len_of(wtype_q);
    assign awsize  = size_of(wtype_q);
    assign awburst = 2'b01;
    assign awvalid = awvalid_q;
    assign wdata   = wbuf_q[cnt_q];
    assign wstrb   = wtype_q[2] ? 4'hf : wstrb_q;
    assign wlast   = 8'(cnt_q) == awlen;
    assign wvalid  = wvalid_q;
    assign bready  = w_state_q == W_RESP;

    assign aw_fin = !awvalid_q || awready;
    assign w_fin  = !wvalid_q || (wready && wlast);

    assign unused_ok = ^{rid, rresp, bid, bresp};

    // Read FSM: latch request, issue AR once no hazard remains, pass R beats straight through.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rtype_q   <= '0;
            arvalid_q <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: if (rd_req && rd_rdy) begin
                    raddr_q   <= rd_addr;
                    rtype_q   <= rd_type;
                    arvalid_q <= !(wr_req && wr_rdy && acc_hz);
                    r_state_q <= R_AR;
                end
                R_AR: if (arvalid_q && arready) begin
                    arvalid_q <= 1'b0;
                    r_state_q <= R_DATA;
                end else if (!ar_hz) arvalid_q <= 1'b1;
                R_DATA: if (rvalid && rlast) r_state_q <= R_IDLE;
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Write FSM: buffer the request, run AW and W independently, then wait for B.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wtype_q   <= '0;
            wstrb_q   <= '0;
            wbuf_q    <= '0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (wr_req && wr_rdy) begin
                    waddr_q   <= wr_addr;
                    wtype_q   <= wr_type;
                    wstrb_q   <= wr_wstrb;
                    wbuf_q    <= wr_data;
                    cnt_q     <= '0;
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    w_state_q <= W_SEND;
                end
                W_SEND: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wvalid_q && wready) begin
                        if (wlast) wvalid_q <= 1'b0;
                        else cnt_q <= cnt_q + 1'b1;
                    end
                    if (aw_fin && w_fin) w_state_q <= W_RESP;
                end
                W_RESP: if (bvalid) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: scoreboard-driven scenario bench for cache_axi_bridge
module tb_cache_axi_bridge;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         rd_req = 1'b0;
    logic [2:0]   rd_type = '0;
    logic [31:0]  rd_addr = '0;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data;
    logic         wr_req = 1'b0;
    logic [2:0]   wr_type = '0;
    logic [31:0]  wr_addr = '0;
    logic [3:0]   wr_wstrb = '0;
    logic [127:0] wr_data = '0;
    logic         wr_rdy;
    logic [3:0]   arid, awid;
    logic [31:0]  araddr, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, awburst;
    logic         arvalid, awvalid, wvalid, wlast, rready, bready;
    logic [3:0]   wstrb;
    logic         arready = 1'b0, awready = 1'b0, wready = 1'b0;
    logic [3:0]   rid = '0, bid = '0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0, bresp = '0;
    logic         rlast = 1'b0, rvalid = 1'b0, bvalid = 1'b0;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [36:0] wq[$];

    cache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    // Compare one W handshake against the oldest expected beat.
    task automatic check_w_beat(input string nm);
        logic [36:0] e;
        total++;
        if (wq.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected beat %h", nm, {wdata, wstrb, wlast});
        end else begin
            e = wq.pop_front();
            if ({wdata, wstrb, wlast} !== e) begin
                bad++;
                $display("FAIL %s: got %h want %h", nm, {wdata, wstrb, wlast}, e);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        total++;
        if ({rd_rdy, wr_rdy, ret_valid, ret_last} !== 4'b0) begin
            bad++;
            $display("FAIL reset_forced: got %b want 0000", {rd_rdy, wr_rdy, ret_valid, ret_last});
        end
        total++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_valids: got %b want 00000", {arvalid, awvalid, wvalid, rready, bready});
        end
        resetn = 1'b1; #1;
        total++;
        if ({rd_rdy, wr_rdy} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release: got %b want 11", {rd_rdy, wr_rdy});
        end
    endtask

    task automatic run_read(input logic [31:0] a, input logic [2:0] t, input logic [7:0] len_e,
                            input logic [2:0] size_e, input int ar_dly, input logic [31:0] d0);
        logic [31:0] e;
        @(negedge clk);
        rd_req = 1'b1; rd_type = t; rd_addr = a; #1;
        total++;
        if (rd_rdy !== 1'b1) begin bad++; $display("FAIL rd_accept: got %b want 1", rd_rdy); end
        for (int i = 0; i <= int'(len_e); i++) exp_q.push_back(d0 + 32'(i) * 32'h11);
        @(negedge clk);
        rd_req = 1'b0; #1;
        total++;
        if ({arvalid, araddr, arlen, arsize, arburst, arid} !== {1'b1, a, len_e, size_e, 2'b01, 4'd0}) begin
            bad++;
            $display("FAIL ar_fields: got %h want %h", {arvalid, araddr, arlen, arsize, arburst, arid},
                     {1'b1, a, len_e, size_e, 2'b01, 4'd0});
        end
        repeat (ar_dly) begin
            @(negedge clk); #1;
            total++;
            if ({arvalid, araddr} !== {1'b1, a}) begin
                bad++;
                $display("FAIL ar_stable: got %h want %h", {arvalid, araddr}, {1'b1, a});
            end
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; #1;
        total++;
        if ({arvalid, rready} !== 2'b01) begin
            bad++;
            $display("FAIL ar_done: got %b want 01", {arvalid, rready});
        end
        for (int i = 0; i <= int'(len_e); i++) begin
            rvalid = 1'b1; rdata = d0 + 32'(i) * 32'h11; rlast = (i == int'(len_e)); #1;
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
            total++;
            if ({ret_valid, ret_last, ret_data, rd_rdy} !== {1'b1, i == int'(len_e), e, 1'b0}) begin
                bad++;
                $display("FAIL ret_beat%0d: got %h want %h", i, {ret_valid, ret_last, ret_data, rd_rdy},
                         {1'b1, i == int'(len_e), e, 1'b0});
            end
            @(negedge clk);
        end
        rvalid = 1'b0; rlast = 1'b0; #1;
        total++;
        if ({ret_valid, rready, rd_rdy} !== 3'b001) begin
            bad++;
            $display("FAIL rd_after: got %b want 001", {ret_valid, rready, rd_rdy});
        end
    endtask

    task automatic test_line_read();
        run_read(32'h1c00_0040, 3'b100, 8'd3, 3'd2, 2, 32'h11);
    endtask

    task automatic test_byte_read();
        run_read(32'h1faf_f003, 3'b000, 8'd0, 3'd0, 1, 32'h5a);
    endtask

    task automatic test_word_write();
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h1000_0008; wr_wstrb = 4'b0011;
        wr_data = 128'hcafe_0000_cafe_0001_cafe_0002_dead_beef; #1;
        total++;
        if (wr_rdy !== 1'b1) begin bad++; $display("FAIL wr_accept: got %b want 1", wr_rdy); end
        wq.push_back({32'hdead_beef, 4'b0011, 1'b1});
        @(negedge clk);
        wr_req = 1'b0; #1;
        total++;
        if ({awvalid, wvalid, wr_rdy, awaddr, awlen, awsize, awburst, awid} !==
            {3'b110, 32'h1000_0008, 8'd0, 3'd2, 2'b01, 4'd1}) begin
            bad++;
            $display("FAIL aw_fields: got %h want %h", {awvalid, wvalid, wr_rdy, awaddr, awlen, awsize, awburst, awid},
                     {3'b110, 32'h1000_0008, 8'd0, 3'd2, 2'b01, 4'd1});
        end
        wready = 1'b1; #1;
        check_w_beat("word_w");
        @(negedge clk);
        wready = 1'b0; #1;
        total++;
        if ({wvalid, awvalid, bready} !== 3'b010) begin
            bad++;
            $display("FAIL w_first: got %b want 010", {wvalid, awvalid, bready});
        end
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0; #1;
        total++;
        if ({awvalid, bready, wr_rdy} !== 3'b010) begin
            bad++;
            $display("FAIL w_resp: got %b want 010", {awvalid, bready, wr_rdy});
        end
        @(negedge clk); #1;
        total++;
        if ({bready, wr_rdy} !== 2'b10) begin
            bad++;
            $display("FAIL b_wait: got %b want 10", {bready, wr_rdy});
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; #1;
        total++;
        if ({bready, wr_rdy} !== 2'b01) begin
            bad++;
            $display("FAIL wr_rdy_back: got %b want 01", {bready, wr_rdy});
        end
    endtask

    task automatic test_line_write();
        int cyc = 0;
        int aw_n = 0;
        logic tog = 1'b1;
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0100; wr_wstrb = 4'b0;
        wr_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111; #1;
        total++;
        if (wr_rdy !== 1'b1) begin bad++; $display("FAIL lw_accept: got %b want 1", wr_rdy); end
        for (int i = 0; i < 4; i++) wq.push_back({32'h1111_1111 * 32'(i + 1), 4'hf, i == 3});
        @(negedge clk);
        wr_req = 1'b0;
        while (!bready && cyc < 40) begin
            awready = 1'b1; wready = tog; #1;
            if (awvalid && awready) aw_n++;
            if (wvalid && wready) check_w_beat("line_w");
            tog = !tog;
            @(negedge clk);
            cyc++;
        end
        awready = 1'b0; wready = 1'b0;
        total++;
        if ({cyc < 40, aw_n, wq.size()} !== {1'b1, 32'd1, 32'd0}) begin
            bad++;
            $display("FAIL lw_summary: got done=%0d aw=%0d left=%0d want 1 1 0", cyc < 40, aw_n, wq.size());
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; #1;
        total++;
        if (wr_rdy !== 1'b1) begin bad++; $display("FAIL lw_done: got %b want 1", wr_rdy); end
    endtask

    task automatic test_hazard();
        int cyc = 0;
        logic exp_by;
`ifdef BRIDGE_RD_BYPASS_EN
        exp_by = 1'b1;
`else
        exp_by = 1'b0;
`endif
        @(negedge clk);
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_0100;
        wr_data = 128'hd4d4_d4d4_c3c3_c3c3_b2b2_b2b2_a1a1_a1a1;
        wq.push_back({32'ha1a1_a1a1, 4'hf, 1'b0});
        wq.push_back({32'hb2b2_b2b2, 4'hf, 1'b0});
        wq.push_back({32'hc3c3_c3c3, 4'hf, 1'b0});
        wq.push_back({32'hd4d4_d4d4, 4'hf, 1'b1});
        @(negedge clk);
        wr_req = 1'b0; rd_type = 3'b100; rd_addr = 32'h0000_0100; #1;
        total++;
        if (rd_rdy !== 1'b0) begin bad++; $display("FAIL hz_same: got %b want 0", rd_rdy); end
        rd_addr = 32'h0000_0200; #1;
        total++;
        if (rd_rdy !== exp_by) begin bad++; $display("FAIL hz_other: got %b want %b", rd_rdy, exp_by); end
        rd_addr = 32'h0000_0100;
        while (!bready && cyc < 20) begin
            awready = 1'b1; wready = 1'b1; #1;
            if (wvalid && wready) check_w_beat("hz_w");
            @(negedge clk);
            cyc++;
        end
        awready = 1'b0; wready = 1'b0; #1;
        total++;
        if ({cyc < 20, wq.size(), rd_rdy} !== {1'b1, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL hz_resp: got done=%0d left=%0d rdy=%b want 1 0 0", cyc < 20, wq.size(), rd_rdy);
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; #1;
        total++;
        if (rd_rdy !== 1'b1) begin bad++; $display("FAIL hz_release: got %b want 1", rd_rdy); end
        run_read(32'h0000_0100, 3'b100, 8'd3, 3'd2, 0, 32'h21);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [31:0] e;
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0300;
        wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_0300; wr_wstrb = 4'hf;
        wr_data = 128'h5555_aaaa; #1;
        total++;
        if ({rd_rdy, wr_rdy} !== 2'b11) begin
            bad++;
            $display("FAIL same_accept: got %b want 11", {rd_rdy, wr_rdy});
        end
        wq.push_back({32'h5555_aaaa, 4'hf, 1'b1});
        exp_q.push_back(32'h77);
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0; #1;
        total++;
        if ({arvalid, awvalid} !== 2'b01) begin
            bad++;
            $display("FAIL same_order: got %b want 01", {arvalid, awvalid});
        end
        awready = 1'b1; wready = 1'b1; #1;
        if (wvalid) check_w_beat("same_w");
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; #1;
        total++;
        if ({bready, arvalid, wq.size()} !== {2'b10, 32'd0}) begin
            bad++;
            $display("FAIL same_resp: got %b%b left=%0d want 10 0", bready, arvalid, wq.size());
        end
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        while (!arvalid && n < 10) begin @(negedge clk); n++; end
        #1;
        total++;
        if ({arvalid, araddr, arlen, arsize} !== {1'b1, 32'h0000_0300, 8'd0, 3'd2}) begin
            bad++;
            $display("FAIL same_ar: got %h want %h", {arvalid, araddr, arlen, arsize}, {1'b1, 32'h0000_0300, 8'd0, 3'd2});
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h77; rlast = 1'b1; #1;
        e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
        total++;
        if ({ret_valid, ret_last, ret_data} !== {2'b11, e}) begin
            bad++;
            $display("FAIL same_ret: got %h want %h", {ret_valid, ret_last, ret_data}, {2'b11, e});
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; #1;
        total++;
        if (rd_rdy !== 1'b1) begin bad++; $display("FAIL same_done: got %b want 1", rd_rdy); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h2000_0000;
        @(negedge clk);
        rd_req = 1'b0; arready = 1'b1;
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'ha1; rlast = 1'b0; #1;
        total++;
        if ({ret_valid, ret_data} !== {1'b1, 32'ha1}) begin
            bad++;
            $display("FAIL rst_beat1: got %h want %h", {ret_valid, ret_data}, {1'b1, 32'ha1});
        end
        @(negedge clk);
        rdata = 32'ha2; resetn = 1'b0; #1;
        total++;
        if ({ret_valid, ret_last, rd_rdy} !== 3'b000) begin
            bad++;
            $display("FAIL rst_forced: got %b want 000", {ret_valid, ret_last, rd_rdy});
        end
        @(negedge clk); #1;
        total++;
        if ({arvalid, rready, ret_valid} !== 3'b000) begin
            bad++;
            $display("FAIL rst_abandon: got %b want 000", {arvalid, rready, ret_valid});
        end
        resetn = 1'b1; rvalid = 1'b0; #1;
        total++;
        if (rd_rdy !== 1'b1) begin bad++; $display("FAIL rst_release: got %b want 1", rd_rdy); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_line_read();
        test_word_write();
        test_line_write();
        test_hazard();
        test_byte_read();
        test_back_to_back();
        test_reset_mid_read();
        total++;
        if (exp_q.size() != 0 || wq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: got rd=%0d wr=%0d want 0 0", exp_q.size(), wq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
